rc_route_unit: RTL and testbench
================================

// Module: rc_route_unit
// PURPOSE
//  Parametrised route-computation unit for one BiNoC router input port, replacing the fixed 4x4 RC.
//  Pops one head flit from the input FIFO, computes the output port by dimension-order routing (XY or YX),
//  requests every bidirectional channel of that port, then holds the flit until a channel grant arrives.
//  Adds a true local-ejection port, runtime router coordinates, a one-hot granted-channel output and a
//  route-error flag for out-of-mesh destinations.
// PARAMETERS
//  DATA_W      32  flit width; destination X at [DATA_W-1 -: COORD_W], Y directly below it
//  COORD_W     2   bits per coordinate
//  MESH_X      4   mesh columns; dst_x >= MESH_X is a route error
//  MESH_Y      4   mesh rows; dst_y >= MESH_Y is a route error
//  NUM_PORTS   5   output ports: 0=X-, 1=Y+, 2=X+, 3=Y-, 4=LOCAL
//  CH_PER_PORT 2   channels per port; channel c of port p is bit p*CH_PER_PORT+c
//  YX_MODE     0   0: resolve X first; 1: resolve Y first
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous reset, active high
//  cur_x        in   COORD_W                this router's X; static after reset
//  cur_y        in   COORD_W                this router's Y; static after reset
//  fifo_empty   in   1                      input FIFO empty
//  fifo_rd      out  1                      one-cycle read request to FIFO
//  fifo_gnt     in   1                      FIFO read grant; fifo_data valid in same cycle
//  fifo_data    in   DATA_W                 head flit from FIFO
//  ch_req       out  NUM_PORTS*CH_PER_PORT  channel requests (all channels of chosen port)
//  ch_gnt       in   NUM_PORTS*CH_PER_PORT  channel grants from arbiter
//  ch_sel       out  NUM_PORTS*CH_PER_PORT  one-hot granted channel, valid for one cycle
//  pkt_out      out  DATA_W                 buffered flit; stable from ROUTE until return to IDLE
//  pkt_valid    out  1                      high while pkt_out holds a routed flit (ROUTE..GRANT)
//  route_err    out  1                      one-cycle pulse: destination outside mesh, flit dropped
// BEHAVIOUR
//  Reset: state=IDLE; fifo_rd, ch_req, ch_sel, pkt_valid, route_err = 0; pkt_out = 0 (never X/Z).
//  FSM IDLE->READ->ROUTE->GRANT->IDLE, all registered outputs.
//   IDLE : fifo_empty=0 -> fifo_rd<=1, go READ; else stay, fifo_rd<=0.
//   READ : fifo_rd<=0 (exactly one-cycle pulse); fifo_gnt=1 -> capture fifo_data into buffer, go ROUTE.
//   ROUTE: decode from buffer, pkt_valid<=1. If dst out of mesh -> route_err<=1, pkt_valid<=0, go IDLE.
//          Else ch_req<= all CH_PER_PORT bits of selected port, go GRANT.
//   GRANT: m = ch_gnt & ch_req. m!=0 -> ch_sel<=lowest set bit of m, ch_req<=0, pkt_valid<=0, go IDLE.
//          m==0 -> hold ch_req and pkt_out; grants on unrequested bits are ignored.
//  Port select (YX_MODE=0): dx<cx->X-, dx>cx->X+, else dy>cy->Y+, dy<cy->Y-, else LOCAL.
//   YX_MODE=1: same compares with Y tested first. Compares unsigned, COORD_W wide.
//  ch_sel and route_err are single-cycle pulses; cleared every cycle otherwise.
//  Latency: fifo_empty falls at T -> fifo_rd at T+1; gnt at T+2 -> ch_req at T+4 earliest; ch_sel one cycle after matching grant.
//  fifo_empty rising after fifo_rd issued: no effect; READ waits indefinitely for fifo_gnt.
//  rst mid-operation: any state returns to IDLE next edge, all outputs cleared, buffered flit discarded.
//  No new fifo_rd while not IDLE; back-to-back packets: earliest next fifo_rd is cycle after GRANT exit.
// STRUCTURE
//  Package noc_pkg: rc_state_e enum, port index localparams (P_XM,P_YP,P_XP,P_YM,P_LOCAL), coord/flit typedefs.
//  Sub-module rc_route_calc: pure combinational dst/cur/mode -> port index + err; reused by future adaptive RC.
//  Lowest-bit priority pick inline (function in noc_pkg).
// TESTING (defaults, cur=(1,2), YX_MODE=0 unless stated)
//  dst=(0,2) head 0x2xxxxxxx-> ch_req=10'b00_0000_0011; ch_gnt=10'b10 -> ch_sel=10'b10, FSM IDLE next.
//  dst=(3,0) XY -> ch_req bits 5:4; same flit with YX_MODE=1 -> ch_req bits 7:6 (Y-).
//  dst=(1,2) -> ch_req=10'b11_0000_0000 (LOCAL); ch_gnt=10'b11_0000_0000 -> ch_sel=10'b01_0000_0000.
//  MESH_X=3, dst_x=3 -> route_err pulse 1 cycle, ch_req stays 0, next flit routed normally.
//  In GRANT with ch_req bits 1:0, ch_gnt=10'b100 for 5 cycles -> ch_req held, no ch_sel, pkt_out stable.
//  rst asserted in READ and in GRANT -> next cycle all outputs 0, IDLE; fifo_rd exactly 1 cycle per flit.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared route-computation types, port indices and helpers
package noc_pkg;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_READ  = 2'd1,
    RC_ROUTE = 2'd2,
    RC_GRANT = 2'd3
  } rc_state_e;

  localparam int P_XM    = 0;
  localparam int P_YP    = 1;
  localparam int P_XP    = 2;
  localparam int P_YM    = 3;
  localparam int P_LOCAL = 4;

  typedef logic [1:0]  coord_t;
  typedef logic [31:0] flit_t;

  // Isolates the least-significant set bit (two's-complement trick); callers zero-extend.
  function automatic logic [31:0] lowest_bit(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/rc_route_unit_if.sv
// rtl/rc_route_unit_if.sv - FIFO-side and channel-side signals of one RC input port
interface rc_route_unit_if #(
  parameter int DATA_W = 32,
  parameter int NCH    = 10
);
  logic              fifo_empty;
  logic              fifo_rd;
  logic              fifo_gnt;
  logic [DATA_W-1:0] fifo_data;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_gnt;
  logic [NCH-1:0]    ch_sel;
  logic [DATA_W-1:0] pkt_out;
  logic              pkt_valid;
  logic              route_err;

  modport master (
    input  fifo_empty, fifo_gnt, fifo_data, ch_gnt,
    output fifo_rd, ch_req, ch_sel, pkt_out, pkt_valid, route_err
  );

  modport slave (
    output fifo_empty, fifo_gnt, fifo_data, ch_gnt,
    input  fifo_rd, ch_req, ch_sel, pkt_out, pkt_valid, route_err
  );
endinterface

// File: rtl/rc_route_calc.sv
// rtl/rc_route_calc.sv - combinational dimension-order port select plus out-of-mesh check
module rc_route_calc
  import noc_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int MESH_X  = 4,
  parameter int MESH_Y  = 4,
  parameter int YX_MODE = 0
) (
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  output logic [2:0]         port,
  output logic               err
);

  always_comb begin
    port = 3'(P_LOCAL);
    if (YX_MODE == 0) begin
      if (dst_x < cur_x)      port = 3'(P_XM);
      else if (dst_x > cur_x) port = 3'(P_XP);
      else if (dst_y > cur_y) port = 3'(P_YP);
      else if (dst_y < cur_y) port = 3'(P_YM);
    end else begin
      if (dst_y > cur_y)      port = 3'(P_YP);
      else if (dst_y < cur_y) port = 3'(P_YM);
      else if (dst_x < cur_x) port = 3'(P_XM);
      else if (dst_x > cur_x) port = 3'(P_XP);
    end
  end

  assign err = (32'(dst_x) >= MESH_X) || (32'(dst_y) >= MESH_Y);

endmodule

// File: rtl/rc_route_unit.sv
// rtl/rc_route_unit.sv - BiNoC input-port route computation: pop head flit, route, request, await grant
module rc_route_unit
  import noc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int COORD_W     = 2,
  parameter int MESH_X      = 4,
  parameter int MESH_Y      = 4,
  parameter int NUM_PORTS   = 5,
  parameter int CH_PER_PORT = 2,
  parameter int YX_MODE     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  rc_route_unit_if.master    bus
);

  localparam int NCH = NUM_PORTS * CH_PER_PORT;

  localparam logic [1:0] S_IDLE  = RC_IDLE;
  localparam logic [1:0] S_READ  = RC_READ;
  localparam logic [1:0] S_ROUTE = RC_ROUTE;
  localparam logic [1:0] S_GRANT = RC_GRANT;

  logic [1:0]        state_q, state_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic [NCH-1:0]    ch_req_q, ch_req_d;
  logic [NCH-1:0]    ch_sel_q, ch_sel_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              route_err_q, route_err_d;

  logic [COORD_W-1:0] dst_x, dst_y;
  logic [2:0]         port;
  logic               err;
  logic [NCH-1:0]     port_mask;
  logic [NCH-1:0]     match;

  assign dst_x = buf_q[DATA_W-1 -: COORD_W];
  assign dst_y = buf_q[DATA_W-1-COORD_W -: COORD_W];

  rc_route_calc #(
    .COORD_W (COORD_W),
    .MESH_X  (MESH_X),
    .MESH_Y  (MESH_Y),
    .YX_MODE (YX_MODE)
  ) u_calc (
    .dst_x (dst_x),
    .dst_y (dst_y),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .port  (port),
    .err   (err)
  );

  assign port_mask = NCH'({CH_PER_PORT{1'b1}}) << (32'(port) * CH_PER_PORT);
  // Grants on channels we never asked for are masked off here.
  assign match     = bus.ch_gnt & ch_req_q;

  always_comb begin
    state_d     = state_q;
    fifo_rd_d   = 1'b0;
    ch_req_d    = ch_req_q;
    ch_sel_d    = '0;
    buf_d       = buf_q;
    pkt_valid_d = pkt_valid_q;
    route_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (bus.fifo_gnt) begin
          buf_d   = bus.fifo_data;
          state_d = S_ROUTE;
        end
      end
      S_ROUTE: begin
        pkt_valid_d = 1'b1;
        if (err) begin
          route_err_d = 1'b1;
          pkt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          ch_req_d = port_mask;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (|match) begin
          ch_sel_d    = NCH'(lowest_bit(32'(match)));
          ch_req_d    = '0;
          pkt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fifo_rd_q   <= 1'b0;
      ch_req_q    <= '0;
      ch_sel_q    <= '0;
      buf_q       <= '0;
      pkt_valid_q <= 1'b0;
      route_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_rd_q   <= fifo_rd_d;
      ch_req_q    <= ch_req_d;
      ch_sel_q    <= ch_sel_d;
      buf_q       <= buf_d;
      pkt_valid_q <= pkt_valid_d;
      route_err_q <= route_err_d;
    end
  end

  assign bus.fifo_rd   = fifo_rd_q;
  assign bus.ch_req    = ch_req_q;
  assign bus.ch_sel    = ch_sel_q;
  assign bus.pkt_out   = buf_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.route_err = route_err_q;

endmodule

// File: tb/tb_rc_route_unit.sv
// tb/tb_rc_route_unit.sv - bench: XY, YX and 3-column-mesh instances of rc_route_unit
module tb_rc_route_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cur_x = 2'd1;
  logic [1:0] cur_y = 2'd2;

  logic        fifo_empty [3];
  logic        fifo_gnt   [3];
  logic [31:0] fifo_data  [3];
  logic [9:0]  ch_gnt     [3];
  logic        rd_o       [3];
  logic [9:0]  req_o      [3];
  logic [9:0]  sel_o      [3];
  logic [31:0] pkt_o      [3];
  logic        vld_o      [3];
  logic        err_o      [3];

  int dut_yx [3] = '{0, 1, 0};
  int dut_mx [3] = '{4, 4, 3};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rc_route_unit_if #(.DATA_W(32), .NCH(10)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rc_route_unit #(
      .DATA_W      (32),
      .COORD_W     (2),
      .MESH_X      ((g == 2) ? 3 : 4),
      .MESH_Y      (4),
      .NUM_PORTS   (5),
      .CH_PER_PORT (2),
      .YX_MODE     ((g == 1) ? 1 : 0)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .cur_x (cur_x),
      .cur_y (cur_y),
      .bus   (ifs[g])
    );
    assign ifs[g].fifo_empty = fifo_empty[g];
    assign ifs[g].fifo_gnt   = fifo_gnt[g];
    assign ifs[g].fifo_data  = fifo_data[g];
    assign ifs[g].ch_gnt     = ch_gnt[g];
    assign rd_o[g]  = ifs[g].fifo_rd;
    assign req_o[g] = ifs[g].ch_req;
    assign sel_o[g] = ifs[g].ch_sel;
    assign pkt_o[g] = ifs[g].pkt_out;
    assign vld_o[g] = ifs[g].pkt_valid;
    assign err_o[g] = ifs[g].route_err;
  end

  typedef struct {
    int          k;
    logic [31:0] data;
    logic [9:0]  gnt;
    logic [9:0]  req;
    logic [9:0]  sel;
    bit          err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input int k, input string name);
    chk({name, "_rd"},  32'(rd_o[k]),  0);
    chk({name, "_req"}, 32'(req_o[k]), 0);
    chk({name, "_sel"}, 32'(sel_o[k]), 0);
    chk({name, "_pkt"}, pkt_o[k],      0);
    chk({name, "_vld"}, 32'(vld_o[k]), 0);
    chk({name, "_err"}, 32'(err_o[k]), 0);
  endtask

  // Reference routing: dimension-order decision straight from the coordinate rules.
  function automatic int model_port(int dx, int dy, int cx, int cy, int yx, int mx, int my);
    if (dx >= mx || dy >= my) return -1;
    if (yx == 0) begin
      if (dx != cx) return (dx < cx) ? 0 : 2;
      if (dy != cy) return (dy > cy) ? 1 : 3;
    end else begin
      if (dy != cy) return (dy > cy) ? 1 : 3;
      if (dx != cx) return (dx < cx) ? 0 : 2;
    end
    return 4;
  endfunction

  function automatic logic [9:0] first_set(input logic [9:0] m);
    for (int i = 0; i < 10; i++) begin
      if (m[i]) return 10'(1) << i;
    end
    return 10'd0;
  endfunction

  task automatic run_flit(input int k, input logic [31:0] data, input int rw, input int gw,
                          input logic [9:0] noise, input logic [9:0] gnt,
                          input logic [9:0] exp_req, input logic [9:0] exp_sel, input bit exp_err);
    fifo_empty[k] = 1'b0;
    step();
    chk("rd_pulse", 32'(rd_o[k]), 1);
    chk("sel_clear", 32'(sel_o[k]), 0);
    fifo_empty[k] = 1'b1;
    for (int i = 0; i < rw; i++) begin
      step();
      chk("rd_once_wait", 32'(rd_o[k]), 0);
    end
    fifo_gnt[k]  = 1'b1;
    fifo_data[k] = data;
    step();
    fifo_gnt[k]  = 1'b0;
    fifo_data[k] = $urandom;
    chk("rd_once_route", 32'(rd_o[k]), 0);
    chk("pkt_capture", pkt_o[k], data);
    step();
    if (exp_err) begin
      chk("err_pulse", 32'(err_o[k]), 1);
      chk("err_valid", 32'(vld_o[k]), 0);
      chk("err_req", 32'(req_o[k]), 0);
      step();
      chk("err_clear", 32'(err_o[k]), 0);
      chk("err_req_after", 32'(req_o[k]), 0);
      return;
    end
    chk("req", 32'(req_o[k]), 32'(exp_req));
    chk("valid", 32'(vld_o[k]), 1);
    chk("err_low", 32'(err_o[k]), 0);
    for (int i = 0; i < gw; i++) begin
      ch_gnt[k] = noise;
      step();
      chk("hold_req", 32'(req_o[k]), 32'(exp_req));
      chk("hold_sel", 32'(sel_o[k]), 0);
      chk("hold_pkt", pkt_o[k], data);
      chk("hold_rd", 32'(rd_o[k]), 0);
    end
    ch_gnt[k] = gnt;
    step();
    ch_gnt[k] = 10'd0;
    chk("sel", 32'(sel_o[k]), 32'(exp_sel));
    chk("req_drop", 32'(req_o[k]), 0);
    chk("valid_drop", 32'(vld_o[k]), 0);
  endtask

  initial begin
    tbl[0] = '{0, 32'h2ABC_0001, 10'h002, 10'h003, 10'h002, 1'b0};
    tbl[1] = '{0, 32'hC000_00F0, 10'h030, 10'h030, 10'h010, 1'b0};
    tbl[2] = '{1, 32'hC000_00F0, 10'h080, 10'h0C0, 10'h080, 1'b0};
    tbl[3] = '{0, 32'h6123_4567, 10'h300, 10'h300, 10'h100, 1'b0};
    tbl[4] = '{2, 32'hC555_0000, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[5] = '{2, 32'hB000_0042, 10'h020, 10'h030, 10'h020, 1'b0};
    tbl[6] = '{0, 32'h7000_0007, 10'h00C, 10'h00C, 10'h004, 1'b0};
    tbl[7] = '{1, 32'h3000_0003, 10'h008, 10'h00C, 10'h008, 1'b0};

    for (int k = 0; k < 3; k++) begin
      fifo_empty[k] = 1'b1;
      fifo_gnt[k]   = 1'b0;
      fifo_data[k]  = 32'd0;
      ch_gnt[k]     = 10'd0;
    end

    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) check_zero(k, "reset");

    for (int i = 0; i < 8; i++) begin
      run_flit(tbl[i].k, tbl[i].data, i % 3, i % 2, 10'd0, tbl[i].gnt,
               tbl[i].req, tbl[i].sel, tbl[i].err);
    end

    // Stall: grant only on an unrequested channel for five cycles.
    run_flit(0, 32'h2000_1234, 1, 5, 10'h004, 10'h002, 10'h003, 10'h002, 1'b0);

    // Reset while waiting in READ.
    fifo_empty[0] = 1'b0;
    step();
    chk("rstrd_rd", 32'(rd_o[0]), 1);
    fifo_empty[0] = 1'b1;
    step();
    chk("rstrd_rd_low", 32'(rd_o[0]), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero(0, "rst_read");
    step();
    chk("rstrd_idle_rd", 32'(rd_o[0]), 0);
    run_flit(0, 32'h2ABC_0001, 0, 0, 10'd0, 10'h001, 10'h003, 10'h001, 1'b0);

    // Reset while holding requests in GRANT.
    fifo_empty[0] = 1'b0;
    step();
    fifo_empty[0] = 1'b1;
    fifo_gnt[0]   = 1'b1;
    fifo_data[0]  = 32'h6000_0055;
    step();
    fifo_gnt[0]   = 1'b0;
    step();
    chk("rstgr_req_pre", 32'(req_o[0]), 32'h300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero(0, "rst_grant");
    step();
    chk("rstgr_idle_rd", 32'(rd_o[0]), 0);
    chk("rstgr_idle_req", 32'(req_o[0]), 0);

    // Randomised flits across all three instances, with fresh coordinates per round.
    for (int r = 0; r < 4; r++) begin
      cur_x = 2'($urandom_range(0, 3));
      cur_y = 2'($urandom_range(0, 3));
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
        int          k;
        int          p;
        logic [31:0] d;
        logic [9:0]  req;
        logic [9:0]  gnt;
        k = $urandom_range(0, 2);
        d = $urandom;
        p = model_port(int'(d[31:30]), int'(d[29:28]), int'(cur_x), int'(cur_y),
                       dut_yx[k], dut_mx[k], 4);
        if (p < 0) begin
          run_flit(k, d, $urandom_range(0, 3), 0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        end else begin
          req = 10'b11 << (2 * p);
          gnt = 10'($urandom) | (10'd1 << (2 * p + $urandom_range(0, 1)));
          run_flit(k, d, $urandom_range(0, 3), $urandom_range(0, 4),
                   10'($urandom) & ~req, gnt, req, first_set(gnt & req), 1'b0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
